// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: the NOP encoding, the default reset PC
// and the instruction-fetch state encoding.
package mips_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    SQUASH = 2'd1,
    HOLD   = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a
// time, and drives registered {npc, inst} into the enable-less IF/ID buffer.
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] npc,
  output logic [31:0] inst,
  output logic        inst_valid
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  npc_q, npc_d;
  logic [31:0]  inst_q, inst_d;
  logic         inst_valid_q, inst_valid_d;
  logic [31:0]  hold_inst_q, hold_inst_d;
  logic [31:0]  hold_npc_q, hold_npc_d;
  // Address of a request being drained after a redirect; pc already holds the target.
  logic [31:0]  sq_addr_q, sq_addr_d;
  logic [31:0]  pc_plus4;

  assign pc_plus4   = pc_q + 32'd4;
  assign imem_req   = rst && (state_q != HOLD);
  assign imem_addr  = (state_q == SQUASH) ? sq_addr_q : pc_q;
  assign npc        = npc_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    npc_d        = npc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    hold_inst_d  = hold_inst_q;
    hold_npc_d   = hold_npc_q;
    sq_addr_d    = sq_addr_q;

    if (redirect) begin
      pc_d         = redirect_pc & 32'hFFFF_FFFC;
      npc_d        = 32'h0;
      inst_d       = NOP_INST;
      inst_valid_d = 1'b0;
      hold_inst_d  = 32'h0;
      hold_npc_d   = 32'h0;
      // An unacknowledged request must keep its address until the memory takes it.
      if (state_q != HOLD && !imem_ack) begin
        state_d = SQUASH;
        if (state_q == FETCH) sq_addr_d = pc_q;
      end else begin
        state_d = FETCH;
      end
    end else begin
      unique case (state_q)
        FETCH: begin
          if (stall) begin
            if (imem_ack) begin
              hold_inst_d = imem_rdata;
              hold_npc_d  = pc_plus4;
              pc_d        = pc_plus4;
              state_d     = HOLD;
            end
          end else if (imem_ack) begin
            inst_d       = imem_rdata;
            npc_d        = pc_plus4;
            inst_valid_d = 1'b1;
            pc_d         = pc_plus4;
          end else begin
            inst_d       = NOP_INST;
            npc_d        = 32'h0;
            inst_valid_d = 1'b0;
          end
        end
        SQUASH: begin
          if (imem_ack) state_d = FETCH;
        end
        HOLD: begin
          if (!stall) begin
            inst_d       = hold_inst_q;
            npc_d        = hold_npc_q;
            inst_valid_d = 1'b1;
            state_d      = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      npc_q        <= 32'h0;
      inst_q       <= NOP_INST;
      inst_valid_q <= 1'b0;
      hold_inst_q  <= 32'h0;
      hold_npc_q   <= 32'h0;
      sq_addr_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      npc_q        <= npc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      hold_inst_q  <= hold_inst_d;
      hold_npc_q   <= hold_npc_d;
      sq_addr_q    <= sq_addr_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: a directed per-cycle vector table followed by
// sequences against a small wait-state memory model.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] npc;
  logic [31:0] inst;
  logic        inst_valid;

  logic        use_model;
  logic        tb_ack;
  logic [31:0] tb_rdata;
  int          mem_lat;
  int          wcnt;
  logic        ack_m;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .npc        (npc),
    .inst       (inst),
    .inst_valid (inst_valid)
  );

  // Memory model: acks after mem_lat wait cycles and returns the address as data.
  always_comb begin
    ack_m      = imem_req && (wcnt >= mem_lat);
    imem_ack   = use_model ? ack_m : tb_ack;
    imem_rdata = use_model ? imem_addr : tb_rdata;
  end

  always @(posedge clk) begin
    if (!rst || !imem_req || ack_m) wcnt <= 0;
    else                            wcnt <= wcnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  typedef struct {
    logic        rst;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        chk_addr;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_npc;
    logic [31:0] e_inst;
    logic        e_valid;
  } vec_t;

  vec_t tv[29];

  task automatic reset_model(input int lat);
    @(negedge clk);
    use_model = 1'b1; mem_lat = lat;
    stall = 0; redirect = 0; redirect_pc = 0; rst = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    rst = 0; stall = 0; redirect = 0; redirect_pc = 0;
    use_model = 0; tb_ack = 0; tb_rdata = 0; mem_lat = 0;

    //        rst stl red rpc           ack rdata          ca req addr          npc           inst          v
    tv[0]  = '{0, 0, 0, 32'h0,         1, 32'h1234_5678, 0, 0, 32'h0,         32'h0,         32'h0,         0};
    tv[1]  = '{0, 0, 0, 32'h0,         0, 32'h0,         1, 0, 32'h0,         32'h0,         32'h0,         0};
    tv[2]  = '{1, 0, 0, 32'h0,         1, 32'hAAAA_0001, 1, 1, 32'h0,         32'h4,         32'hAAAA_0001, 1};
    tv[3]  = '{1, 0, 0, 32'h0,         0, 32'h0,         1, 1, 32'h4,         32'h0,         32'h0,         0};
    tv[4]  = '{1, 0, 0, 32'h0,         1, 32'h1111,      1, 1, 32'h4,         32'h8,         32'h1111,      1};
    tv[5]  = '{1, 1, 0, 32'h0,         0, 32'h0,         1, 1, 32'h8,         32'h8,         32'h1111,      1};
    tv[6]  = '{1, 1, 0, 32'h0,         1, 32'h2222,      1, 1, 32'h8,         32'h8,         32'h1111,      1};
    tv[7]  = '{1, 1, 0, 32'h0,         0, 32'h0,         1, 0, 32'hC,         32'h8,         32'h1111,      1};
    tv[8]  = '{1, 0, 0, 32'h0,         0, 32'h0,         1, 0, 32'hC,         32'hC,         32'h2222,      1};
    tv[9]  = '{1, 0, 0, 32'h0,         1, 32'h3333,      1, 1, 32'hC,         32'h10,        32'h3333,      1};
    tv[10] = '{1, 0, 1, 32'h103,       0, 32'h0,         1, 1, 32'h10,        32'h0,         32'h0,         0};
    tv[11] = '{1, 0, 0, 32'h0,         0, 32'h0,         1, 1, 32'h10,        32'h0,         32'h0,         0};
    tv[12] = '{1, 0, 1, 32'h100,       0, 32'h0,         1, 1, 32'h10,        32'h0,         32'h0,         0};
    tv[13] = '{1, 0, 0, 32'h0,         1, 32'hDEAD,      1, 1, 32'h10,        32'h0,         32'h0,         0};
    tv[14] = '{1, 0, 0, 32'h0,         1, 32'h4444,      1, 1, 32'h100,       32'h104,       32'h4444,      1};
    tv[15] = '{1, 0, 1, 32'h300,       1, 32'h5555,      1, 1, 32'h104,       32'h0,         32'h0,         0};
    tv[16] = '{1, 0, 0, 32'h0,         1, 32'h6666,      1, 1, 32'h300,       32'h304,       32'h6666,      1};
    tv[17] = '{1, 1, 0, 32'h0,         1, 32'h7777,      1, 1, 32'h304,       32'h304,       32'h6666,      1};
    tv[18] = '{1, 1, 1, 32'h400,       0, 32'h0,         1, 0, 32'h308,       32'h0,         32'h0,         0};
    tv[19] = '{1, 0, 0, 32'h0,         1, 32'h8888,      1, 1, 32'h400,       32'h404,       32'h8888,      1};
    tv[20] = '{1, 1, 1, 32'h500,       0, 32'h0,         1, 1, 32'h404,       32'h0,         32'h0,         0};
    tv[21] = '{1, 1, 0, 32'h0,         1, 32'h9,         1, 1, 32'h404,       32'h0,         32'h0,         0};
    tv[22] = '{1, 0, 0, 32'h0,         1, 32'hA,         1, 1, 32'h500,       32'h504,       32'hA,         1};
    tv[23] = '{1, 0, 1, 32'hFFFF_FFFF, 1, 32'hEEEE,      1, 1, 32'h504,       32'h0,         32'h0,         0};
    tv[24] = '{1, 0, 0, 32'h0,         1, 32'hB,         1, 1, 32'hFFFF_FFFC, 32'h0,         32'hB,         1};
    tv[25] = '{1, 0, 1, 32'h40,        0, 32'h0,         1, 1, 32'h0,         32'h0,         32'h0,         0};
    tv[26] = '{1, 0, 0, 32'h0,         0, 32'h0,         1, 1, 32'h0,         32'h0,         32'h0,         0};
    tv[27] = '{0, 0, 0, 32'h0,         1, 32'hBAD,       0, 0, 32'h0,         32'h0,         32'h0,         0};
    tv[28] = '{1, 0, 0, 32'h0,         1, 32'hC,         1, 1, 32'h0,         32'h4,         32'hC,         1};

    for (int i = 0; i < 29; i++) begin
      @(negedge clk);
      rst = tv[i].rst; stall = tv[i].stall; redirect = tv[i].redir;
      redirect_pc = tv[i].rpc; tb_ack = tv[i].ack; tb_rdata = tv[i].rdata;
      #1;
      chk($sformatf("v%0d req", i), {31'h0, imem_req}, {31'h0, tv[i].e_req});
      if (tv[i].chk_addr) chk($sformatf("v%0d addr", i), imem_addr, tv[i].e_addr);
      @(posedge clk); #1;
      chk($sformatf("v%0d npc", i), npc, tv[i].e_npc);
      chk($sformatf("v%0d inst", i), inst, tv[i].e_inst);
      chk($sformatf("v%0d valid", i), {31'h0, inst_valid}, {31'h0, tv[i].e_valid});
    end

    // Zero-wait memory, addr as data: one instruction per cycle.
    reset_model(0);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("zw%0d npc", k), npc, 32'(4 * k + 4));
      chk($sformatf("zw%0d inst", k), inst, 32'(4 * k));
      chk($sformatf("zw%0d valid", k), {31'h0, inst_valid}, 32'h1);
    end

    // Two wait cycles: two bubbles per instruction, address held while requesting.
    reset_model(2);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        if (j != 0) @(negedge clk);
        #1;
        chk($sformatf("w2 %0d.%0d req", k, j), {31'h0, imem_req}, 32'h1);
        chk($sformatf("w2 %0d.%0d addr", k, j), imem_addr, 32'(4 * k));
        @(posedge clk); #1;
        if (j < 2) begin
          chk($sformatf("w2 %0d.%0d bubble inst", k, j), inst, 32'h0);
          chk($sformatf("w2 %0d.%0d bubble valid", k, j), {31'h0, inst_valid}, 32'h0);
        end else begin
          chk($sformatf("w2 %0d npc", k), npc, 32'(4 * k + 4));
          chk($sformatf("w2 %0d inst", k), inst, 32'(4 * k));
          chk($sformatf("w2 %0d valid", k), {31'h0, inst_valid}, 32'h1);
        end
      end
      @(negedge clk);
    end

    // One-wait memory, 3-cycle stall with the ack landing mid-stall.
    reset_model(1);
    @(posedge clk); #1;
    chk("st c0 valid", {31'h0, inst_valid}, 32'h0);
    @(posedge clk); #1;
    chk("st c1 npc", npc, 32'h4);
    chk("st c1 inst", inst, 32'h0);
    for (int c = 2; c < 5; c++) begin
      @(negedge clk);
      stall = 1;
      #1;
      if (c == 4) chk("st hold req", {31'h0, imem_req}, 32'h0);
      @(posedge clk); #1;
      chk($sformatf("st c%0d npc", c), npc, 32'h4);
      chk($sformatf("st c%0d inst", c), inst, 32'h0);
      chk($sformatf("st c%0d valid", c), {31'h0, inst_valid}, 32'h1);
    end
    @(negedge clk);
    stall = 0;
    @(posedge clk); #1;
    chk("st rel npc", npc, 32'h8);
    chk("st rel inst", inst, 32'h4);
    chk("st rel valid", {31'h0, inst_valid}, 32'h1);
    chk("st rel req", {31'h0, imem_req}, 32'h1);
    chk("st rel addr", imem_addr, 32'h8);
    @(posedge clk); #1;
    chk("st c6 valid", {31'h0, inst_valid}, 32'h0);
    @(posedge clk); #1;
    chk("st c7 npc", npc, 32'hC);
    chk("st c7 inst", inst, 32'h8);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch stage of the five-stage MIPS pipeline. Owns the program counter and issues single-outstanding requests to instruction memory. It drives registered {npc, inst} into the IF/ID pipeline buffer and handles hazard-unit stalls and branch/jump redirects. Because the IF/ID buffer has no enable, a stall is realised by holding these outputs stable, and a flush by presenting a NOP bubble.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- stall  in  1  hazard unit: hold IF outputs, do not advance.
- redirect  in  1  taken branch/jump resolved; flush and refetch.
- redirect_pc  in  32  target PC, valid when redirect=1.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, word aligned.
- imem_ack  in  1  request accepted; imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- npc  out  32  PC+4 of the instruction on inst; to IF/ID buffer.
- inst  out  32  fetched instruction; 32'h0 (NOP) when bubble.
- inst_valid  out  1  inst holds a real instruction.

## Operation
- Registers: pc, state, npc, inst, inst_valid, hold_inst, hold_npc.
- FSM states:
  - FETCH: imem_req=1, imem_addr=pc.
  - SQUASH: imem_req=1, imem_addr=old pc; response is discarded.
  - HOLD: imem_req=0; hold_* carries a fetched instruction.
- Memory protocol:
  - imem_req and imem_addr stay stable until imem_ack is sampled high.
  - imem_ack may arrive in the first request cycle (zero-wait).
  - There is never more than one request outstanding.
- Per-cycle priority, highest first: rst=0, redirect, stall, normal.
- rst=0:
  - pc=RESET_PC, state=FETCH, npc=0, inst=0, inst_valid=0, hold_*=0.
  - imem_req is forced 0 during the reset cycle.
  - A request in flight is abandoned; the memory ignores an ack that arrives during reset.
- redirect=1 (any state):
  - pc<=redirect_pc; outputs <= bubble (npc=0, inst=0, inst_valid=0); hold_* discarded.
  - If in FETCH with imem_ack=0: next state SQUASH, keeping the old address stable.
  - Otherwise (ack this cycle, or state HOLD): next state FETCH at redirect_pc; any ack data is dropped.
  - A redirect in SQUASH overwrites pc again and stays in SQUASH.
- SQUASH, no redirect: on imem_ack, discard the data and go to FETCH; stall is ignored.
- FETCH, no redirect, stall=0:
  - On ack: inst<=imem_rdata, npc<=pc+4, inst_valid<=1, pc<=pc+4.
  - No ack: outputs <= bubble.
- FETCH, stall=1:
  - Outputs hold their values.
  - On ack: hold_inst<=imem_rdata, hold_npc<=pc+4, pc<=pc+4, go to HOLD.
- HOLD:
  - stall=1: remain in HOLD, outputs hold.
  - stall=0: inst<=hold_inst, npc<=hold_npc, inst_valid<=1, go to FETCH.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0 with no error. redirect_pc[1:0] is ignored (forced 00).

## Timing
- Zero-wait memory: ack in cycle N puts the instruction on the outputs after edge N. The IF/ID buffer captures it at edge N+1. Sustained throughput is 1 instruction/cycle.
- A memory latency of L wait cycles inserts L bubbles per instruction.
- Redirect to first target instruction on outputs: 1 cycle plus memory latency, plus the remaining latency of the squashed request if one was outstanding.
- Stall release from HOLD: the held instruction appears 1 cycle later; the next request issues in that same cycle.
- imem_addr and imem_req are combinational from pc/state only. There is no combinational path from imem_ack or stall to the outputs.

## Structure
- Shared package mips_pkg holds:
  - NOP_INST=32'h0.
  - The default RESET_PC.
  - The fetch-state enum {FETCH, SQUASH, HOLD}.
- Single module; no sub-module warranted. Estimated 150-250 lines.

## Test plan
- Reset, zero-wait memory returning addr as data: after rst deasserts, outputs (npc, inst) are (4,0), (8,4), (12,8)…, 1 per cycle, inst_valid=1 from the first ack onward.
- 2-wait-cycle memory: each instruction is followed by 2 bubble cycles (inst=0, inst_valid=0); imem_addr is stable while imem_req is high.
- stall for 3 cycles with an ack arriving mid-stall: outputs frozen for all 3 cycles; HOLD entered with imem_req=0; the held instruction is presented the cycle after stall drops; no instruction is lost or duplicated.
- Redirect to 32'h0000_0100 while a request is outstanding: outputs bubble next cycle; old address held until ack; ack data discarded; next request is at 0x100 and yields npc=0x104.
- Redirect and ack in the same cycle, and redirect during stall: redirect wins, ack data dropped, fetch resumes at redirect_pc.
- rst asserted mid-request and pc=32'hFFFF_FFFC: outputs return to 0, imem_req=0, restart at RESET_PC; the wrap case fetches 0 next.
